// File: rtl/wide_add_seq.sv
// wide_add_seq: wide adder built from one shared 16-bit slice, LSB slice first, one slice per clock.
// Define WIDE_ADD_SEQ_SUB_EN to add a 'sub' port that selects a-b (cout=1 means no borrow).
module wide_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  input  logic                cin,
`ifdef WIDE_ADD_SEQ_SUB_EN
  input  logic                sub,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*WORDS-1:0] sum,
  output logic                cout,
  output logic                busy
);
  localparam int W  = 16*WORDS;
  localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state, nxt;
  logic [W-1:0]  a_q, b_q, b_in;
  logic [IW-1:0] idx;
  logic          carry, c_in, c, last;
  logic [15:0]   s;
`ifdef WIDE_ADD_SEQ_SUB_EN
  // two's-complement subtract: invert B and force the initial carry
  assign b_in = sub ? ~b : b;
  assign c_in = sub | cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif
  assign last   = idx == IW'(WORDS-1);
  assign {c, s} = {1'b0, a_q[16*idx +: 16]} + {1'b0, b_q[16*idx +: 16]} + {16'b0, carry};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && in_valid) begin
        a_q   <= a;
        b_q   <= b_in;
        carry <= c_in;
        idx   <= '0;
        sum   <= '0;
        cout  <= 1'b0;
      end else if (state == RUN) begin
        sum[16*idx +: 16] <= s;
        carry             <= c;
        idx               <= last ? idx : idx + 1'b1;
        if (last) cout <= c;
      end
    end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid) nxt = RUN;
      RUN:     if (last) nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    busy      = state != IDLE;
  end
endmodule
